// File: rtl/pipe_reg_slice_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_slice_if
// Purpose  : Handshake bundle for pipe_reg_slice. It carries the upstream
//            valid/ready/data channel, the downstream valid/ready/data
//            channel, the synchronous flush request and the occupancy count.
// Ports    : flush      - discard all held words on the next edge
//            in_valid   - upstream word present
//            in_data    - upstream word [WIDTH]
//            in_ready   - slice accepts a word this cycle
//            out_valid  - output stage holds a word
//            out_data   - output stage word [WIDTH]
//            out_ready  - downstream accepts a word this cycle
//            occupancy  - number of valid stages [clog2(DEPTH+1)]
// Modports : master - the side driving the slice (producer/consumer/control)
//            slave  - the slice itself
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_reg_slice_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_slice
// Purpose  : DEPTH-stage valid/ready register pipeline. Each stage holds one
//            WIDTH-bit word plus a valid bit. Ready is propagated
//            combinationally from out_ready back through the stages, so
//            empty stages (bubbles) are absorbed and a full pipe sustains
//            one word per cycle. No combinational path exists from the
//            input data/valid to the output data/valid.
// Params   : WIDTH     - data bits per word
//            DEPTH     - register stages, 1..16
//            ZERO_IDLE - 1: out_data forced to 0 while out_valid=0
//                        0: out_data shows the output-stage register
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - pipe_reg_slice_if.slave (flush, in_*, out_*, occupancy)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_slice #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 2,
  parameter int ZERO_IDLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_reg_slice_if.slave       bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Packed/array views of the per-stage registers held in g_stage.
  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];

  // w_adv[i]: stage i may load from its source on this edge.
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [DEPTH-1:0] w_valid_nxt;
  logic             w_flush;

  logic [OCC_W-1:0] r_occ;

  assign w_flush = bus.flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      assign w_valid[gi] = r_valid;
      assign w_data[gi]  = r_data;

      // A stage advances when it is empty or its successor advances.
      // Unrolled along the chain this is: out_ready, or any stage from
      // here to the output stage is empty. Written in closed form so no
      // bit of w_adv depends on another bit of w_adv.
      assign w_adv[gi] = bus.out_ready | ~(&w_valid[DEPTH-1:gi]);

      if (gi == 0) begin : g_src_in
        assign w_src_valid[gi] = bus.in_valid;
        assign w_src_data[gi]  = bus.in_data;
      end else begin : g_src_prev
        assign w_src_valid[gi] = w_valid[gi-1];
        assign w_src_data[gi]  = w_data[gi-1];
      end

      // Flush overrides every transfer; otherwise a stage that can advance
      // takes its predecessor's valid bit and a stalled stage keeps its own.
      assign w_valid_nxt[gi] = ~w_flush & (w_adv[gi] ? w_src_valid[gi] : r_valid);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= w_valid_nxt[gi];
          // Data only moves with a real word, so an emptied stage keeps its
          // last contents (visible at the output when ZERO_IDLE=0) and a
          // word offered during flush never reaches a data register.
          if (w_adv[gi] && w_src_valid[gi] && !w_flush) begin
            r_data <= w_src_data[gi];
          end
        end
      end
    end
  endgenerate

  // Occupancy tracks the valid bits on the same edge they update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= OCC_W'($countones(w_valid_nxt));
    end
  end

  // rst_n gates in_ready so nothing is offered as accepted during reset,
  // even though an all-empty pipe would otherwise look ready.
  assign bus.in_ready  = rst_n & w_adv[0] & ~w_flush;
  assign bus.out_valid = w_valid[DEPTH-1];
  assign bus.occupancy = r_occ;

  generate
    if (ZERO_IDLE != 0) begin : g_zero_idle
      assign bus.out_data = w_valid[DEPTH-1] ? w_data[DEPTH-1] : '0;
    end else begin : g_hold_idle
      assign bus.out_data = w_data[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_reg_slice
// Purpose  : Directed and random checks of pipe_reg_slice.
//            u0: WIDTH=5 DEPTH=2 ZERO_IDLE=1 (stream, backpressure, flush,
//                async reset)
//            u1: WIDTH=8 DEPTH=4 ZERO_IDLE=1 (random stress, scoreboard)
//            u2: WIDTH=5 DEPTH=2 ZERO_IDLE=0 (stale output data)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_slice;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_reg_slice_if #(.WIDTH(5), .DEPTH(2)) b0 ();
  pipe_reg_slice_if #(.WIDTH(8), .DEPTH(4)) b1 ();
  pipe_reg_slice_if #(.WIDTH(5), .DEPTH(2)) b2 ();

  pipe_reg_slice #(.WIDTH(5), .DEPTH(2), .ZERO_IDLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  pipe_reg_slice #(.WIDTH(8), .DEPTH(4), .ZERO_IDLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_reg_slice #(.WIDTH(5), .DEPTH(2), .ZERO_IDLE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle on u0: drive inputs, check in_ready before the edge, then
  // check outputs and occupancy just after the edge.
  task automatic cyc(input string tag, input logic iv, input logic [4:0] id,
                     input logic ordy, input logic fl, input logic e_ir,
                     input logic e_ov, input logic [4:0] e_od, input logic [1:0] e_occ);
    b0.in_valid  = iv;
    b0.in_data   = id;
    b0.out_ready = ordy;
    b0.flush     = fl;
    #1;
    chk({tag, ".in_ready"}, b0.in_ready, e_ir);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, b0.out_valid, e_ov);
    chk({tag, ".out_data"},  b0.out_data,  e_od);
    chk({tag, ".occupancy"}, b0.occupancy, e_occ);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int occ_m;
    int exp_d;
    logic exp_ir;

    rst_n = 1'b0;
    b0.flush = 0; b0.in_valid = 0; b0.in_data = 0; b0.out_ready = 1;
    b1.flush = 0; b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0;
    b2.flush = 0; b2.in_valid = 0; b2.in_data = 0; b2.out_ready = 0;

    // ---------------- reset state ----------------
    #3;
    chk("rst.out_valid", b0.out_valid, 0);
    chk("rst.out_data",  b0.out_data,  0);
    chk("rst.occupancy", b0.occupancy, 0);
    chk("rst.in_ready",  b0.in_ready,  0);
    chk("rst.u1_occ",    b1.occupancy, 0);
    chk("rst.u2_data",   b2.out_data,  0);
    #19;
    rst_n = 1'b1;

    // ---------------- streaming ----------------
    //   tag    iv id    ordy fl  ir ov od    occ
    cyc("s1",  1, 5'h01, 1, 0,  1, 0, 5'h00, 1);
    cyc("s2",  1, 5'h02, 1, 0,  1, 1, 5'h01, 2);
    cyc("s3",  1, 5'h03, 1, 0,  1, 1, 5'h02, 2);
    cyc("s4",  0, 5'h00, 1, 0,  1, 1, 5'h03, 1);
    cyc("s5",  0, 5'h00, 1, 0,  1, 0, 5'h00, 0);
    cyc("s6",  0, 5'h00, 0, 0,  1, 0, 5'h00, 0);

    // ---------------- backpressure ----------------
    cyc("b1",  1, 5'h0A, 0, 0,  1, 0, 5'h00, 1);
    cyc("b2",  1, 5'h0B, 0, 0,  1, 1, 5'h0A, 2);
    cyc("b3",  1, 5'h0C, 0, 0,  0, 1, 5'h0A, 2);
    cyc("b4",  1, 5'h0C, 0, 0,  0, 1, 5'h0A, 2);
    cyc("b5",  1, 5'h0C, 1, 0,  1, 1, 5'h0B, 2);
    cyc("b6",  0, 5'h00, 1, 0,  1, 1, 5'h0C, 1);
    cyc("b7",  0, 5'h00, 1, 0,  1, 0, 5'h00, 0);

    // ---------------- flush ----------------
    cyc("f1",  1, 5'h11, 0, 0,  1, 0, 5'h00, 1);
    cyc("f2",  1, 5'h12, 0, 0,  1, 1, 5'h11, 2);
    cyc("f3",  1, 5'h1F, 1, 1,  0, 0, 5'h00, 0);
    cyc("f4",  0, 5'h00, 1, 0,  1, 0, 5'h00, 0);
    cyc("f5",  0, 5'h00, 1, 0,  1, 0, 5'h00, 0);

    // ---------------- asynchronous reset ----------------
    cyc("a1",  1, 5'h07, 0, 0,  1, 0, 5'h00, 1);
    cyc("a2",  1, 5'h08, 0, 0,  1, 1, 5'h07, 2);
    b0.in_valid = 0;
    b0.out_ready = 1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", b0.out_valid, 0);
    chk("ar.out_data",  b0.out_data,  0);
    chk("ar.occupancy", b0.occupancy, 0);
    chk("ar.in_ready",  b0.in_ready,  0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc("a3",  1, 5'h09, 1, 0,  1, 0, 5'h00, 1);
    cyc("a4",  0, 5'h00, 1, 0,  1, 1, 5'h09, 1);
    cyc("a5",  0, 5'h00, 1, 0,  1, 0, 5'h00, 0);

    // ---------------- ZERO_IDLE=0 ----------------
    b2.in_valid = 1; b2.in_data = 5'h15; b2.out_ready = 1;
    #1;
    chk("z.in_ready", b2.in_ready, 1);
    @(posedge clk); #1;
    b2.in_valid = 0; b2.in_data = 5'h00;
    chk("z.occ1", b2.occupancy, 1);
    @(posedge clk); #1;
    chk("z.out_valid1", b2.out_valid, 1);
    chk("z.out_data1",  b2.out_data,  5'h15);
    @(posedge clk); #1;
    chk("z.out_valid0", b2.out_valid, 0);
    chk("z.out_data0",  b2.out_data,  5'h15);
    chk("z.occ0",       b2.occupancy, 0);
    @(posedge clk); #1;
    chk("z.out_data_hold", b2.out_data, 5'h15);

    // ---------------- random stress (DEPTH=4, WIDTH=8) ----------------
    occ_m = 0;
    for (int c = 0; c < 10000 && n_fail < 50; c++) begin
      b1.in_valid  = ($urandom_range(0, 9) < 6);
      b1.in_data   = 8'($urandom);
      b1.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ir = b1.out_ready || (occ_m < 4);
      chk("st.in_ready", b1.in_ready, exp_ir);
      if (occ_m == 0) chk("st.empty_out_valid", b1.out_valid, 0);
      if (b1.out_valid && b1.out_ready) begin
        if (q.size() == 0) begin
          chk("st.spurious_out", b1.out_valid, 0);
        end else begin
          exp_d = q.pop_front();
          chk("st.out_data", b1.out_data, exp_d);
          occ_m--;
        end
      end
      if (b1.in_valid && exp_ir) begin
        q.push_back(int'(b1.in_data));
        occ_m++;
      end
      @(posedge clk); #1;
      chk("st.occupancy", b1.occupancy, occ_m);
    end

    // Drain whatever is left.
    b1.in_valid = 0;
    b1.out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (b1.out_valid) begin
        if (q.size() == 0) begin
          chk("dr.spurious_out", b1.out_valid, 0);
        end else begin
          exp_d = q.pop_front();
          chk("dr.out_data", b1.out_data, exp_d);
        end
      end
      @(posedge clk); #1;
    end
    chk("dr.left_in_model", q.size(), 0);
    chk("dr.occupancy", b1.occupancy, 0);
    chk("dr.out_valid", b1.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_reg_slice.md
PIPE_REG_SLICE -- requirements
Module: pipe_reg_slice

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning data bits per word.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of register stages (legal range 1..16).
REQ-003 The block SHALL have parameter ZERO_IDLE, default 1, meaning out_data is forced to 0 whenever out_valid=0 (0: out_data holds the last stage register contents).
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port flush  input  1  synchronous discard of all held words.
REQ-007 The block SHALL have port in_valid  input  1  upstream word present.
REQ-008 The block SHALL have port in_data  input  WIDTH  upstream word.
REQ-009 The block SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-010 The block SHALL have port out_valid  output  1  last stage holds a word.
REQ-011 The block SHALL have port out_data  output  WIDTH  last stage word.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts a word this cycle.
REQ-013 The block SHALL have port occupancy  output  clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Stage 0 SHALL be the input stage and stage DEPTH-1 the output stage, each holding a WIDTH-bit data register and a valid bit.
REQ-015 Transfers SHALL occur only on a rising clk edge: input when in_valid and in_ready are 1; output when out_valid and out_ready are 1.
REQ-016 A stage SHALL be able to advance when it is empty or its successor advances; the output stage advances when out_ready=1.
REQ-017 Stage-ready SHALL be computed combinationally back from out_ready, so that a full pipe with out_ready=1 sustains one word per cycle.
REQ-018 in_ready SHALL equal stage-0 ready AND NOT flush.
REQ-019 When stage i+1 is able to advance, it SHALL load data and valid from stage i; a stage that cannot advance holds its data and valid.
REQ-020 Unstalled latency SHALL be DEPTH cycles: a word accepted at edge N is presented with out_valid=1 after edge N+DEPTH-1 and transferred at edge N+DEPTH at the earliest.
REQ-021 Words SHALL leave in acceptance order, with no loss and no duplication, under any pattern of in_valid and out_ready.
REQ-022 out_valid SHALL equal the output-stage valid bit.
REQ-023 out_data SHALL equal the output-stage data when out_valid=1.
REQ-024 When out_valid=0, out_data SHALL be 0 if ZERO_IDLE=1, and the stale output-stage register if ZERO_IDLE=0.
REQ-025 occupancy SHALL equal the number of set valid bits (range 0..DEPTH) and update on the same edge as the valid bits.
REQ-026 Flush SHALL take priority over all transfers.
REQ-027 On a clk edge with flush=1, all valid bits SHALL clear; any in_data offered that cycle is dropped, in_ready is 0 that cycle, and occupancy becomes 0.
REQ-028 On a flush edge, data registers MAY retain their contents but SHALL NOT be visible when ZERO_IDLE=1.
REQ-029 Full boundary: with occupancy=DEPTH and out_ready=0, in_ready SHALL be 0 and the pipe contents SHALL be frozen.
REQ-030 Empty boundary: with occupancy=0, out_valid SHALL be 0; in_valid=0 leaves the state unchanged.
REQ-031 Simultaneous input and output transfers with a full pipe SHALL keep occupancy at DEPTH.
REQ-032 A simultaneous input and output transfer SHALL change occupancy by 0.
REQ-033 An input-only transfer SHALL change occupancy by +1, and an output-only transfer by -1.
REQ-034 No combinational path SHALL exist from in_valid or in_data to out_valid or out_data.

Reset
REQ-035 While rst_n=0, all valid bits, all data registers and occupancy SHALL be 0 asynchronously, independent of clk.
REQ-036 While rst_n=0, out_valid, out_data and in_ready SHALL be 0.
REQ-037 Assertion of rst_n mid-transfer SHALL discard all words.
REQ-038 Operation SHALL resume on the first rising clk edge after rst_n=1.

Verification
REQ-039 Streaming: WIDTH=5, DEPTH=2, out_ready=1, words 0x01,0x02,0x03 on consecutive cycles -> out_data 0x01,0x02,0x03 on consecutive cycles, first one 2 edges after acceptance.
REQ-040 Backpressure: DEPTH=2, out_ready=0, offer 0x0A,0x0B,0x0C -> 0x0A and 0x0B accepted, occupancy=2, in_ready=0, 0x0C held; then out_ready=1 -> 0x0A,0x0B,0x0C in order with no gaps.
REQ-041 Flush: occupancy=2, flush=1 for one cycle with in_valid=1 and in_data=0x1F -> occupancy=0, out_valid=0, out_data=0 (ZERO_IDLE=1), and 0x1F never appears.
REQ-042 Async reset: rst_n driven 0 between clk edges with occupancy=2 -> out_valid=0, occupancy=0 immediately; after release, first accepted word exits after DEPTH edges.
REQ-043 Random stress: DEPTH=4, WIDTH=8, random in_valid and out_ready for 10000 cycles -> output sequence equals input sequence and occupancy always matches a scoreboard count.
REQ-044 ZERO_IDLE=0: drain 0x15 -> out_valid=0 and out_data remains 0x15.
